// File: rtl/adf_serial_loader.sv
// adf_serial_loader
//
// Serial register loader for ADF-family PLL synthesizers. A START request in
// IDLE captures one 32-bit register word. The word is shifted out MSB first on
// ADF_DATA_OUT, and each bit is framed by one low and one high phase of
// ADF_CLK_OUT. Each phase lasts CLK_DIV system clocks. After the 32nd high
// phase, ADF_CLK_OUT is held low for one more half-period of setup. ADF_LE_OUT
// then pulses for LE_CYCLES clocks to latch the word, and DONE pulses for one
// cycle. All serial-side outputs come straight from flops.
//
// A separate path, independent of the loader, brings the asynchronous
// lock-detect input in through a two-flop synchronizer. It raises a sticky
// LOCK_LOST flag whenever the synchronized lock indication drops.
//
// Parameters
//   CLK_DIV        SCLK half-period in system clocks (1..255)
//   LE_CYCLES      LE high width in system clocks (1..255)
// Ports
//   CLK            system clock, rising edge
//   RST_N          synchronous active-low reset
//   START          request to load DATA_IN (ignored unless idle)
//   DATA_IN        32-bit register word, shifted MSB first
//   BUSY           transfer in progress
//   DONE           one-cycle completion pulse
//   ADF_CLK_OUT    serial clock to synthesizer
//   ADF_DATA_OUT   serial data to synthesizer
//   ADF_LE_OUT     load enable to synthesizer
//   ADF_LD_IN      asynchronous lock detect from synthesizer
//   LD_SYNC        synchronized lock detect
//   LOCK_LOST      sticky lock-lost flag
//   CLR_LOCK_LOST  clears LOCK_LOST (a coincident new loss wins)

module adf_serial_loader #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned LE_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic [31:0] DATA_IN,
  output logic        BUSY,
  output logic        DONE,
  output logic        ADF_CLK_OUT,
  output logic        ADF_DATA_OUT,
  output logic        ADF_LE_OUT,
  input  logic        ADF_LD_IN,
  output logic        LD_SYNC,
  output logic        LOCK_LOST,
  input  logic        CLR_LOCK_LOST
);

  // Each phase counter is loaded with length-1 and the phase ends when it hits 0.
  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] LE_LOAD  = 8'(LE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LE_SETUP,
    LE_HIGH,
    FINISH
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  div_cnt_q, div_cnt_d;

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        adf_clk_q, adf_clk_d;
  logic        adf_data_q, adf_data_d;
  logic        adf_le_q, adf_le_d;

  logic        ld_meta_q, ld_meta_d;
  logic        ld_sync_q, ld_sync_d;
  logic        ld_prev_q, ld_prev_d;
  logic        lock_lost_q, lock_lost_d;
  logic        lock_fall;

  // Transfer FSM: state and datapath registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      div_cnt_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      adf_clk_q  <= 1'b0;
      adf_data_q <= 1'b0;
      adf_le_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      div_cnt_q  <= div_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      adf_clk_q  <= adf_clk_d;
      adf_data_q <= adf_data_d;
      adf_le_q   <= adf_le_d;
    end
  end

  // Transfer FSM: next state and datapath
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (START) begin
          shift_d   = DATA_IN;
          bit_cnt_d = '0;
          div_cnt_d = DIV_LOAD;
          state_d   = SHIFT_LO;
        end
      end

      SHIFT_LO: begin
        if (div_cnt_q == '0) begin
          div_cnt_d = DIV_LOAD;
          state_d   = SHIFT_HI;
        end else begin
          div_cnt_d = div_cnt_q - 8'd1;
        end
      end

      SHIFT_HI: begin
        if (div_cnt_q == '0) begin
          shift_d   = {shift_q[30:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 6'd1;
          div_cnt_d = DIV_LOAD;
          state_d   = (bit_cnt_q == 6'd31) ? LE_SETUP : SHIFT_LO;
        end else begin
          div_cnt_d = div_cnt_q - 8'd1;
        end
      end

      LE_SETUP: begin
        if (div_cnt_q == '0) begin
          div_cnt_d = LE_LOAD;
          state_d   = LE_HIGH;
        end else begin
          div_cnt_d = div_cnt_q - 8'd1;
        end
      end

      LE_HIGH: begin
        if (div_cnt_q == '0) begin
          div_cnt_d = '0;
          state_d   = FINISH;
        end else begin
          div_cnt_d = div_cnt_q - 8'd1;
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The outputs decode the *next* state and are registered beside the state
  // flop. They therefore change on the same edge as the state and stay
  // glitch-free. SCLK falls on the same edge that the next bit is presented.
  always_comb begin
    busy_d     = (state_d == SHIFT_LO) || (state_d == SHIFT_HI) ||
                 (state_d == LE_SETUP) || (state_d == LE_HIGH);
    done_d     = (state_d == FINISH);
    adf_clk_d  = (state_d == SHIFT_HI);
    adf_le_d   = (state_d == LE_HIGH);
    adf_data_d = 1'b0;
    if ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) begin
      adf_data_d = shift_d[31];
    end
  end

  // Lock-detect synchronizer and sticky loss flag
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ld_meta_q   <= 1'b0;
      ld_sync_q   <= 1'b0;
      ld_prev_q   <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      ld_meta_q   <= ld_meta_d;
      ld_sync_q   <= ld_sync_d;
      ld_prev_q   <= ld_prev_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  // The fall is detected on the registered copy of LD_SYNC, so LOCK_LOST
  // rises one cycle after LD_SYNC drops.
  always_comb begin
    ld_meta_d   = ADF_LD_IN;
    ld_sync_d   = ld_meta_q;
    ld_prev_d   = ld_sync_q;
    lock_fall   = ld_prev_q & ~ld_sync_q;
    lock_lost_d = lock_lost_q;
    if (lock_fall) begin
      lock_lost_d = 1'b1;
    end else if (CLR_LOCK_LOST) begin
      lock_lost_d = 1'b0;
    end
  end

  assign BUSY         = busy_q;
  assign DONE         = done_q;
  assign ADF_CLK_OUT  = adf_clk_q;
  assign ADF_DATA_OUT = adf_data_q;
  assign ADF_LE_OUT   = adf_le_q;
  assign LD_SYNC      = ld_sync_q;
  assign LOCK_LOST    = lock_lost_q;

endmodule

// File: doc/adf_serial_loader.md
ADF_SERIAL_LOADER -- requirements
Module: adf_serial_loader

Interface
REQ-001 Parameter CLK_DIV, default 4, SCLK half-period in system clocks (legal range 1..255).
REQ-002 Parameter LE_CYCLES, default 4, LE high width in system clocks (legal range 1..255).
REQ-003 CLK  input  1  system clock; all logic on rising edge.
REQ-004 RST_N  input  1  synchronous, active-low reset.
REQ-005 START  input  1  request to load one 32-bit word; sampled every cycle.
REQ-006 DATA_IN  input  32  synthesizer register word (control bits included), shifted out MSB first.
REQ-007 BUSY  output  1  high while a word transfer is in progress.
REQ-008 DONE  output  1  one-cycle pulse on transfer completion.
REQ-009 ADF_CLK_OUT  output  1  serial clock to the synthesizer.
REQ-010 ADF_DATA_OUT  output  1  serial data to the synthesizer.
REQ-011 ADF_LE_OUT  output  1  load-enable to the synthesizer.
REQ-012 ADF_LD_IN  input  1  asynchronous lock-detect from the synthesizer.
REQ-013 LD_SYNC  output  1  lock-detect after two-flop synchronizer.
REQ-014 LOCK_LOST  output  1  sticky flag, set on falling edge of LD_SYNC.
REQ-015 CLR_LOCK_LOST  input  1  one-cycle clear of LOCK_LOST.

Function
REQ-016 FSM states: IDLE, SHIFT_LO, SHIFT_HI, LE_SETUP, LE_HIGH, FINISH.
REQ-017 IDLE: START=1 at edge k latches DATA_IN into a 32-bit shift register, clears 6-bit bit counter, loads divider counter, moves to SHIFT_LO; BUSY=1 from cycle k+1.
REQ-018 START while BUSY=1 is ignored; DATA_IN is not re-sampled mid-transfer.
REQ-019 SHIFT_LO: ADF_CLK_OUT=0, ADF_DATA_OUT=current MSB of shift register, held CLK_DIV cycles, then SHIFT_HI.
REQ-020 SHIFT_HI: ADF_CLK_OUT=1, ADF_DATA_OUT unchanged, held CLK_DIV cycles; on exit shift register shifts left one, bit counter increments.
REQ-021 After 32nd SHIFT_HI, go to LE_SETUP: ADF_CLK_OUT=0, ADF_DATA_OUT=0, held CLK_DIV cycles.
REQ-022 LE_HIGH: ADF_LE_OUT=1 for exactly LE_CYCLES cycles, ADF_CLK_OUT=0.
REQ-023 FINISH: one cycle with DONE=1, BUSY=0, ADF_LE_OUT=0; then IDLE.
REQ-024 Timing: START at edge k -> BUSY high cycles k+1 .. k+T with T = 65*CLK_DIV + LE_CYCLES; DONE high in cycle k+T+1 only.
REQ-025 START in the FINISH cycle is ignored; START in the cycle after FINISH is accepted (back-to-back minimum gap one cycle).
REQ-026 ADF_DATA_OUT changes only while ADF_CLK_OUT=0; no output glitches (all three ADF outputs registered).
REQ-027 ADF_LE_OUT never high while ADF_CLK_OUT high; exactly 32 rising ADF_CLK_OUT edges per transfer.
REQ-028 LD_SYNC = ADF_LD_IN delayed by two CLK cycles.
REQ-029 LOCK_LOST set in the cycle after LD_SYNC transitions 1->0; cleared by CLR_LOCK_LOST; simultaneous set and clear -> set wins.
REQ-030 Lock-detect logic is independent of the transfer FSM.

Reset
REQ-031 RST_N=0 at any edge, including mid-transfer: FSM to IDLE, shift register and counters to 0, BUSY=0, DONE=0, ADF_CLK_OUT=0, ADF_DATA_OUT=0, ADF_LE_OUT=0, synchronizer flops 0, LD_SYNC=0, LOCK_LOST=0.
REQ-032 Reset mid-transfer produces no ADF_LE_OUT pulse and no DONE; partially shifted word is discarded.
REQ-033 START asserted in the same cycle RST_N=0 is ignored.

Verification
REQ-034 CLK_DIV=2, LE_CYCLES=2, START one cycle with DATA_IN=0x00580005 -> 32 SCLK rises, captured bits on rising edges = 0x00580005 MSB first, BUSY 132 cycles, LE high 2 cycles, DONE one pulse at cycle k+133.
REQ-035 START held high continuously with DATA_IN=0xA5A5A5A5 then 0x5A5A5A5A at DONE -> second transfer starts cycle after FINISH, captures 0x5A5A5A5A, no overlap of LE and SCLK.
REQ-036 START pulses during BUSY -> ignored, single DONE, captured word equals first DATA_IN.
REQ-037 RST_N low at 10th SCLK rise -> all outputs 0 next cycle, no LE, no DONE; new START afterwards completes normally.
REQ-038 ADF_LD_IN 0->1->0 -> LD_SYNC follows two cycles late, LOCK_LOST=1 one cycle after LD_SYNC falls; CLR_LOCK_LOST coincident with a new fall -> LOCK_LOST stays 1.
